key_debounce: RTL and testbench

//  Input-side companion to the LED drivers: filters KEY_W raw active-low push-buttons

---
 rtl/key_debounce.sv | 126 ++++++++++++
 tb/tb_key_debounce.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key 2-FF synchroniser and debounce FSM for active-low push-buttons
// Produces a clean pressed level plus single-cycle press, release and long-press events.
module key_debounce #(
   parameter int KEY_W        = 2,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 100_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] key_down,
   output logic [KEY_W-1:0] key_press,
   output logic [KEY_W-1:0] key_release,
   output logic [KEY_W-1:0] key_long
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILT_DN = 2'd1,
      DOWN    = 2'd2,
      FILT_UP = 2'd3
   } state_e;

   localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYC - 1);
   localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);

   for (genvar g = 0; g < KEY_W; g++) begin : g_key
      logic        s1_q;
      logic        s2_q;
      state_e      state_q;
      logic [31:0] cnt_q;
      logic [31:0] lcnt_q;
      logic [31:0] lcnt_d;
      logic        down_q;
      logic        press_q;
      logic        release_q;
      logic        long_q;

      // Sync flops reset to the released level so a held key after reset still sees a falling edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
         end else begin
            s1_q <= key[g];
            s2_q <= s1_q;
         end
      end

      // Long-press counter saturates at its terminal value so key_long fires once per press.
      always_comb begin
         lcnt_d = lcnt_q;
         if (state_q == DOWN && lcnt_q < LONG_LAST) begin
            lcnt_d = lcnt_q + 32'd1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            lcnt_q    <= 32'd0;
            down_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
               IDLE: begin
                  if (!s2_q) begin
                     state_q <= FILT_DN;
                     cnt_q   <= 32'd0;
                  end
               end
               FILT_DN: begin
                  if (s2_q) begin
                     state_q <= IDLE;
                     cnt_q   <= 32'd0;
                  end else if (cnt_q == DB_LAST) begin
                     state_q <= DOWN;
                     press_q <= 1'b1;
                     down_q  <= 1'b1;
                     lcnt_q  <= 32'd0;
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
               DOWN: begin
                  lcnt_q <= lcnt_d;
                  if (lcnt_d == LONG_LAST && lcnt_q != LONG_LAST) begin
                     long_q <= 1'b1;
                  end
                  if (s2_q) begin
                     state_q <= FILT_UP;
                     cnt_q   <= 32'd0;
                  end
               end
               FILT_UP: begin
                  if (!s2_q) begin
                     state_q <= DOWN;
                  end else if (cnt_q == DB_LAST) begin
                     state_q   <= IDLE;
                     release_q <= 1'b1;
                     down_q    <= 1'b0;
                     lcnt_q    <= 32'd0;
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end

      assign key_down[g]    = down_q;
      assign key_press[g]   = press_q;
      assign key_release[g] = release_q;
      assign key_long[g]    = long_q;
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with short debounce/long-press timing
module tb_key_debounce;

   localparam int DB = 16;
   localparam int LC = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] key = 2'b11;
   logic [1:0] key_down;
   logic [1:0] key_press;
   logic [1:0] key_release;
   logic [1:0] key_long;

   key_debounce #(
      .KEY_W       (2),
      .DEBOUNCE_CYC(DB),
      .LONG_CYC    (LC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .key_down   (key_down),
      .key_press  (key_press),
      .key_release(key_release),
      .key_long   (key_long)
   );

   always #5 clk = ~clk;

   int ec = 0;
   always @(posedge clk) ec <= ec + 1;

   typedef struct {
      int         cyc;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] lng;
   } ev_t;

   typedef struct {
      int         cyc;
      logic [1:0] down;
   } lv_t;

   ev_t ev_q[$];
   lv_t lv_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   bit  end_req = 1'b0;
   bit  end_done = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      lv_t l;
      if ((key_press | key_release | key_long) != 2'b00) begin
         n_cmp++;
         if (ev_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b long=%b required no pulse",
                     ec, key_press, key_release, key_long);
         end else begin
            e = ev_q.pop_front();
            if (e.cyc != ec || key_press !== e.press || key_release !== e.rel || key_long !== e.lng) begin
               n_err++;
               $display("FAIL event got cyc=%0d press=%b release=%b long=%b required cyc=%0d press=%b release=%b long=%b",
                        ec, key_press, key_release, key_long, e.cyc, e.press, e.rel, e.lng);
            end
         end
      end
      while (lv_q.size() > 0 && lv_q[0].cyc <= ec) begin
         l = lv_q.pop_front();
         n_cmp++;
         if (l.cyc != ec || key_down !== l.down) begin
            n_err++;
            $display("FAIL key_down cyc=%0d got %b required %b (check cyc %0d)", ec, key_down, l.down, l.cyc);
         end
      end
      if (end_req && !end_done) begin
         n_cmp++;
         if (ev_q.size() != 0 || lv_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expectations got events=%0d levels=%0d required 0/0", ev_q.size(), lv_q.size());
         end
         end_done = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_ev(input int cyc, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
      ev_q.push_back('{cyc: cyc, press: p, rel: r, lng: l});
   endtask

   task automatic exp_lv(input int cyc, input logic [1:0] d);
      lv_q.push_back('{cyc: cyc, down: d});
   endtask

   task automatic drain();
      int k = 0;
      while ((ev_q.size() != 0 || lv_q.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int b;
      int c;
      int g;

      // Reset with keys released, then idle
      rst_n = 1'b0;
      key   = 2'b11;
      exp_lv(2, 2'b00);
      exp_lv(3, 2'b00);
      tick(4);
      rst_n = 1'b1;
      b = ec;
      exp_lv(b + 50, 2'b00);
      exp_lv(b + 100, 2'b00);
      tick(100);

      // Clean press and release on key 0
      b = ec;
      key = 2'b10;
      exp_lv(b + DB + 2, 2'b00);
      exp_lv(b + DB + 3, 2'b01);
      exp_ev(b + DB + 3, 2'b01, 2'b00, 2'b00);
      tick(40);
      b = ec;
      key = 2'b11;
      exp_lv(b + DB + 2, 2'b01);
      exp_lv(b + DB + 3, 2'b00);
      exp_ev(b + DB + 3, 2'b00, 2'b01, 2'b00);
      tick(30);
      drain();

      // Bouncing key 1 never gets accepted
      for (int i = 0; i < 5; i++) begin
         key = 2'b01;
         exp_lv(ec + 4, 2'b00);
         tick(5);
         key = 2'b11;
         exp_lv(ec + 4, 2'b00);
         tick(5);
      end
      exp_lv(ec + 25, 2'b00);
      tick(30);
      drain();

      // Long press on key 0
      b = ec;
      key = 2'b10;
      exp_ev(b + DB + 3, 2'b01, 2'b00, 2'b00);
      exp_lv(b + DB + 3, 2'b01);
      exp_ev(b + DB + 3 + LC - 1, 2'b00, 2'b00, 2'b01);
      exp_lv(b + 100, 2'b01);
      tick(120);
      b = ec;
      key = 2'b11;
      exp_ev(b + DB + 3, 2'b00, 2'b01, 2'b00);
      exp_lv(b + DB + 3, 2'b00);
      tick(30);
      drain();

      // Both keys together, then a short release glitch on key 0
      b = ec;
      key = 2'b00;
      exp_ev(b + DB + 3, 2'b11, 2'b00, 2'b00);
      exp_lv(b + DB + 3, 2'b11);
      tick(30);
      g = ec;
      key = 2'b01;
      exp_lv(g + 3, 2'b11);
      exp_lv(g + 8, 2'b11);
      tick(4);
      key = 2'b00;
      tick(6);
      b = ec;
      key = 2'b11;
      exp_ev(b + DB + 3, 2'b00, 2'b11, 2'b00);
      exp_lv(b + DB + 3, 2'b00);
      tick(30);
      drain();

      // Reset while key 1 is down and key 0 is mid-filter
      b = ec;
      key = 2'b01;
      exp_ev(b + DB + 3, 2'b10, 2'b00, 2'b00);
      tick(25);
      c = ec;
      key = 2'b00;
      exp_lv(c + 13, 2'b10);
      tick(13);
      #2;
      rst_n = 1'b0;
      exp_lv(c + 14, 2'b00);
      tick(3);
      rst_n = 1'b1;
      b = ec;
      exp_lv(b + DB + 2, 2'b00);
      exp_lv(b + DB + 3, 2'b11);
      exp_ev(b + DB + 3, 2'b11, 2'b00, 2'b00);
      tick(30);
      b = ec;
      key = 2'b11;
      exp_ev(b + DB + 3, 2'b00, 2'b11, 2'b00);
      exp_lv(b + DB + 3, 2'b00);
      tick(30);
      drain();

      end_req = 1'b1;
      tick(3);
      if (!end_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL end_check got not_done required done");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
